// File: rtl/fft_frame_writer.sv
// Frame-buffer writer: collects one FFT spectrum over a valid/ready stream, then rasterises it as
// vertical colour-coded bars, one pixel per clock. Optional peak-hold markers under `PEAK_HOLD_EN`.
module fft_frame_writer #(
    parameter int unsigned H_PIXELS  = 640,
    parameter int unsigned V_PIXELS  = 480,
    parameter int unsigned NUM_BINS  = 64,
    parameter int unsigned MAG_WIDTH = 9
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        bin_valid,
    output logic                        bin_ready,
    input  logic [$clog2(NUM_BINS)-1:0] bin_index,
    input  logic [MAG_WIDTH-1:0]        bin_mag,
    input  logic                        bin_last,
    output logic                        wr_en,
    output logic [18:0]                 wr_addr,
    output logic [2:0]                  wr_data,
    output logic                        ready,
    output logic                        busy
);

    localparam int unsigned B_W   = $clog2(NUM_BINS);
    localparam int unsigned X_W   = $clog2(H_PIXELS);
    localparam int unsigned Y_W   = $clog2(V_PIXELS);
    localparam int unsigned BAR_W = H_PIXELS / NUM_BINS;
    localparam int unsigned C_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [X_W-1:0] X_LAST    = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST    = Y_W'(V_PIXELS - 1);
    localparam logic [C_W-1:0] SUB_LAST  = C_W'(BAR_W - 1);
    localparam logic [18:0]    ADDR_LAST = 19'(H_PIXELS * V_PIXELS - 1);

    typedef enum logic {COLLECT, DRAW} state_t;

    state_t               state, state_next;
    logic                 alive;
    logic                 accept, go_draw, frame_done, issue;
    logic [MAG_WIDTH-1:0] mag_clamped;
    logic [MAG_WIDTH-1:0] heights [NUM_BINS];

    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [B_W-1:0]       bin;
    logic [C_W-1:0]       sub;
    logic [18:0]          addr;
    logic                 scan_done;

    logic                 v1;
    logic [18:0]          addr1;
    logic [Y_W-1:0]       y1;
    logic [B_W-1:0]       bin1;
    logic [MAG_WIDTH-1:0] h1;
    logic [MAG_WIDTH-1:0] p1;
    logic [B_W+2:0]       code_prod;
    logic [2:0]           bar_code, pix_code;
    logic                 lit, peak_hit;

    assign accept      = bin_valid && bin_ready;
    assign go_draw     = accept && bin_last;
    assign frame_done  = wr_en && (wr_addr == ADDR_LAST);
    assign issue       = (state == DRAW) && !scan_done;
    assign mag_clamped = (32'(bin_mag) > V_PIXELS) ? MAG_WIDTH'(V_PIXELS) : bin_mag;

    // NOTE: sequential state uses <= so every register samples pre-edge values in parallel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
            alive <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            alive <= 1'b1;
            if (frame_done)
                ready <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        bin_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            COLLECT: begin
                bin_ready = alive;
                if (go_draw)
                    state_next = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                if (frame_done)
                    state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    // NOTE: the heights array is flops, not RAM, so it can and must clear on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BINS; i++)
                heights[i] <= '0;
        end else if (accept) begin
            heights[bin_index] <= mag_clamped;
        end
    end

`ifdef PEAK_HOLD_EN
    logic [MAG_WIDTH-1:0] peaks [NUM_BINS];

    function automatic logic [MAG_WIDTH-1:0] peak_next(input logic [MAG_WIDTH-1:0] h,
                                                       input logic [MAG_WIDTH-1:0] p);
        logic [MAG_WIDTH-1:0] p_dec;
        p_dec = (p == '0) ? '0 : p - MAG_WIDTH'(1);
        return (h > p_dec) ? h : p_dec;
    endfunction

    // Updated on the accept that starts DRAW, folding in the height landing on that same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BINS; i++)
                peaks[i] <= '0;
        end else if (go_draw) begin
            for (int i = 0; i < NUM_BINS; i++)
                peaks[i] <= peak_next((bin_index == B_W'(i)) ? mag_clamped : heights[i], peaks[i]);
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            bin       <= '0;
            sub       <= '0;
            addr      <= '0;
            scan_done <= 1'b0;
        end else if (state != DRAW) begin
            x         <= '0;
            y         <= '0;
            bin       <= '0;
            sub       <= '0;
            addr      <= '0;
            scan_done <= 1'b0;
        end else if (!scan_done) begin
            addr <= addr + 19'd1;
            if (addr == ADDR_LAST)
                scan_done <= 1'b1;
            if (x == X_LAST) begin
                x   <= '0;
                sub <= '0;
                bin <= '0;
                y   <= (y == Y_LAST) ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
                if (sub == SUB_LAST) begin
                    sub <= '0;
                    bin <= bin + B_W'(1);
                end else begin
                    sub <= sub + C_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            addr1 <= '0;
            y1    <= '0;
            bin1  <= '0;
            h1    <= '0;
            p1    <= '0;
        end else begin
            v1    <= issue;
            addr1 <= addr;
            y1    <= y;
            bin1  <= bin;
            h1    <= heights[bin];
`ifdef PEAK_HOLD_EN
            p1    <= peaks[bin];
`else
            p1    <= '0;
`endif
        end
    end

    assign code_prod = (B_W + 3)'(bin1) * (B_W + 3)'(7);
    assign bar_code  = 3'd1 + 3'(code_prod >> B_W);
    assign lit       = (32'(y1) + 32'(h1)) >= V_PIXELS;
    assign peak_hit  = (p1 != '0) && ((32'(y1) + 32'(p1)) == V_PIXELS);
    assign pix_code  = peak_hit ? 3'd7 : (lit ? bar_code : 3'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= v1;
            wr_addr <= addr1;
            wr_data <= v1 ? pix_code : 3'd0;
        end
    end

endmodule

// File: tb/tb_fft_frame_writer.sv
// Self-checking bench for fft_frame_writer on a reduced 32x24 raster with 8 bins; the expected
// image is computed pixel by pixel from a model of bar heights (and peaks when PEAK_HOLD_EN is set).
module tb_fft_frame_writer;

    localparam int H  = 32;
    localparam int V  = 24;
    localparam int NB = 8;
    localparam int MW = 6;
    localparam int BW = 3;
    localparam int N  = H * V;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          bin_valid = 1'b0;
    logic          bin_last  = 1'b0;
    logic [BW-1:0] bin_index = '0;
    logic [MW-1:0] bin_mag   = '0;
    logic          bin_ready, wr_en, ready, busy;
    logic [18:0]   wr_addr;
    logic [2:0]    wr_data;

    fft_frame_writer #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .NUM_BINS (NB),
        .MAG_WIDTH(MW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bin_valid(bin_valid),
        .bin_ready(bin_ready),
        .bin_index(bin_index),
        .bin_mag  (bin_mag),
        .bin_last (bin_last),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int heights_m [NB];
    int peaks_m   [NB];
    bit ready_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NB; i++) begin
            heights_m[i] = 0;
            peaks_m[i]   = 0;
        end
        ready_m = 1'b0;
    endtask

    task automatic model_accept(input int idx, input int mag, input bit last);
        heights_m[idx] = (mag > V) ? V : mag;
        if (last)
            for (int i = 0; i < NB; i++) begin
                int dec;
                dec = (peaks_m[i] > 0) ? peaks_m[i] - 1 : 0;
                peaks_m[i] = (heights_m[i] > dec) ? heights_m[i] : dec;
            end
    endtask

    function automatic int exp_pix(input int a);
        int x, y, b, code;
        x    = a % H;
        y    = a / H;
        b    = x / (H / NB);
        code = 0;
        if (y >= V - heights_m[b])
            code = 1 + (b * 7) / NB;
`ifdef PEAK_HOLD_EN
        if (peaks_m[b] > 0 && y == V - peaks_m[b])
            code = 7;
`endif
        return code;
    endfunction

    task automatic send_bin(input int idx, input int mag, input bit last, input int gap);
        bit done, rdy;
        repeat (gap) tick;
        bin_valid = 1'b1;
        bin_index = BW'(idx);
        bin_mag   = MW'(mag);
        bin_last  = last;
        done      = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            rdy = bin_ready;
            tick;
            if (rdy)
                done = 1'b1;
        end
        check("bin accepted", 32'(done), 32'd1);
        if (done)
            model_accept(idx, mag, last);
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int n;
        n = 0;
        while (wr_en !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check({tag, " wr_en start"}, 32'(wr_en), 32'd1);
        if (wr_en !== 1'b1)
            return;
        check({tag, " busy in draw"}, 32'(busy), 32'd1);
        check({tag, " bin_ready in draw"}, 32'(bin_ready), 32'd0);
        check({tag, " ready before end"}, 32'(ready), 32'(ready_m));
        for (int i = 0; i < N; i++) begin
            logic [22:0] obs, exp;
            obs = {wr_en, wr_addr, wr_data};
            exp = {1'b1, 19'(i), 3'(exp_pix(i))};
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s pixel %0d: observed en/addr/data %0h expected %0h", tag, i, obs, exp);
            end
            tick;
        end
        ready_m = 1'b1;
        check({tag, " wr_en after end"}, 32'(wr_en), 32'd0);
        check({tag, " ready after end"}, 32'(ready), 32'd1);
        check({tag, " busy after end"}, 32'(busy), 32'd0);
        check({tag, " bin_ready after end"}, 32'(bin_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        model_reset();

        // Reset held: every output low.
        #23;
        check("reset wr_en", 32'(wr_en), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset bin_ready", 32'(bin_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick;
        check("release bin_ready", 32'(bin_ready), 32'd1);
        check("release ready", 32'(ready), 32'd0);

        // Single short bar in bin 0.
        send_bin(0, 5, 1'b1, 0);
        check_frame("single");

        // Clamped full-height bar in the last bin.
        send_bin(0, 0, 1'b0, 0);
        send_bin(7, 63, 1'b1, 1);
        check_frame("clamp");

        // Random spectra, partial updates, random gaps.
        for (int f = 0; f < 3; f++) begin
            k = $urandom_range(1, NB + 2);
            for (int j = 0; j < k; j++)
                send_bin($urandom_range(0, NB - 1), $urandom_range(0, 63), j == k - 1,
                         $urandom_range(0, 2));
            check_frame("random");
        end

        // Bin offered during DRAW must stall until the frame completes.
        send_bin(7, 20, 1'b1, 0);
        bin_valid = 1'b1;
        bin_index = BW'(7);
        bin_mag   = MW'(2);
        bin_last  = 1'b0;
        check_frame("stall");
        tick;
        model_accept(7, 2, 1'b0);
        bin_valid = 1'b0;
        send_bin(3, 10, 1'b1, 0);
        check_frame("after stall");

        // Peak marker sequence (plain bars when peak hold is not built in).
        for (int i = 0; i < NB; i++)
            send_bin(i, 0, 1'b0, 0);
        send_bin(5, 10, 1'b1, 0);
        check_frame("peak frame 1");
        send_bin(5, 0, 1'b1, 0);
        check_frame("peak frame 2");

        // Reset in the middle of a frame.
        send_bin(1, 12, 1'b1, 0);
        n = 0;
        while (!(wr_en === 1'b1 && wr_addr === 19'd100) && n < 500) begin
            tick;
            n++;
        end
        check("midframe reached addr 100", 32'(wr_addr), 32'd100);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset wr_en", 32'(wr_en), 32'd0);
        check("midreset wr_addr", 32'(wr_addr), 32'd0);
        check("midreset ready", 32'(ready), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset bin_ready", 32'(bin_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick;
        check("midrelease bin_ready", 32'(bin_ready), 32'd1);
        check("midrelease ready", 32'(ready), 32'd0);
        send_bin(2, 7, 1'b1, 0);
        check_frame("post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
